fir_seq_ctrl: RTL
=================

// Module: fir_seq_ctrl
// PURPOSE
//   Sample-history buffer and sequencer for the stereo FIR filter blocks. Holds the last
//   TAPS left/right samples from the codec path in a circular buffer. On each new sample,
//   drives the filter's sequencing input for one full multiply-accumulate pass, and
//   streams the sample history to the filter in lock-step with its coefficient address.
//   Signals when the filtered result on the filter outputs is valid.
// PARAMETERS
//   TAPS  1021  number of filter taps = samples kept in history = accumulate cycles per pass
//   AW    10    pointer/counter width; must satisfy 2**AW >= TAPS+2
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   wrt_smpl    in   1   1-cycle strobe: new stereo sample on lft_in/rht_in
//   lft_in      in   16  signed left sample, sampled when wrt_smpl=1
//   rht_in      in   16  signed right sample, sampled when wrt_smpl=1
//   clr_ovr     in   1   clears the overrun flag
//   sequencing  out  1   to filter; high for exactly TAPS+1 consecutive cycles per pass
//   lft_out     out  16  signed history sample to filter (left)
//   rht_out     out  16  signed history sample to filter (right)
//   filt_vld    out  1   1-cycle pulse: filter filtered_L/R now hold the new result
//   primed      out  1   history buffer holds TAPS samples; passes are enabled
//   overrun     out  1   sticky: a sample was lost because one was already pending
// BEHAVIOUR
//   Reset (async, any state, including mid-pass):
//     - Outputs: sequencing=0, lft_out/rht_out=0, filt_vld=0, primed=0, overrun=0.
//     - Internal: write ptr=0, fill count=0, holding register empty; state FILL.
//     - Buffer contents are don't-care after reset.
//   States:
//     FILL  Each wrt_smpl writes the buffer at wptr; wptr and fill count advance.
//           When count reaches TAPS, go to IDLE and set primed=1. Samples are never lost here.
//     IDLE  On wrt_smpl, write the buffer at wptr, advance wptr, and go to RUN.
//           Output sequencing stays low in IDLE.
//     RUN   Lasts TAPS+1 cycles; sequencing=1 throughout.
//           Cycle c=0 is the filter's accumulator-clear cycle; lft_out/rht_out are don't-care.
//           Cycles c=1..TAPS present history sample (wptr_at_entry + c-1) mod TAPS.
//           This order is oldest first; the newest sample appears at c=TAPS.
//           The sample for cycle c must be on lft_out/rht_out during cycle c.
//           Buffer read is therefore issued in cycle c-1, matching the 1-cycle ROM latency.
//     DONE  One cycle. sequencing=0 (mandatory gap: the filter re-arms only on a low cycle).
//           filt_vld=1. If the holding register is full, commit it to the buffer, advance
//           wptr, empty the holding register, and go to RUN. Otherwise go to IDLE.
//   Timing: with wrt_smpl in IDLE at cycle t, the sample is written at the end of t.
//     RUN spans t+1..t+1+TAPS; DONE and filt_vld fall at t+2+TAPS.
//     Latency from wrt_smpl to filt_vld is TAPS+2 cycles.
//   Samples arriving during RUN or DONE:
//     - The sample is latched into a 1-deep holding register; it never writes the buffer
//       mid-pass.
//     - If the register is already full, the new sample overwrites it and overrun=1.
//     - Sample committed in DONE plus a simultaneous wrt_smpl in that cycle:
//       the new one goes to the holding register with no overrun.
//   Pointer wrap: wptr wraps TAPS-1 -> 0. The read index wraps the same way.
//   overrun: set has priority over clr_ovr in the same cycle. It is cleared only by
//     clr_ovr or reset.
//   Width: samples pass through unmodified, signed 16-bit. No arithmetic on data.
// TESTING  (TAPS=8, AW=4 unless noted)
//   - Fill: reset, 7 strobes with values 1..7. Expect primed=0 and sequencing never high.
//     8th strobe: primed=1, still no pass.
//   - Pass: after fill 1..8, strobe 9 at t. Expect sequencing high t+1..t+9.
//     lft_out = 2,3,4,5,6,7,8,9 in t+2..t+9; filt_vld at t+10.
//   - Back-to-back: strobe 10 during RUN. Expect DONE with sequencing low for 1 cycle,
//     then a new pass showing 3..10, with overrun=0.
//   - Overrun: two strobes (11, 12) during one RUN. Expect overrun=1 and next pass ends
//     with 12; 11 never appears. Then clr_ovr clears it.
//   - Reset mid-RUN at c=4. Expect all outputs 0 immediately, state FILL,
//     8 strobes needed before the next pass.
//   - Default TAPS=1021 with an impulse stored in history. Expect 1022-cycle sequencing
//     window, and filter output equals the ROM coefficient sequence.

Source files
------------

// File: rtl/fir_seq_ctrl_if.sv
// rtl/fir_seq_ctrl_if.sv - sample/control bundle between codec path, history sequencer and FIR filter
interface fir_seq_ctrl_if;
  logic               wrt_smpl;
  logic signed [15:0] lft_in;
  logic signed [15:0] rht_in;
  logic               clr_ovr;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rht_out;
  logic               filt_vld;
  logic               primed;
  logic               overrun;

  modport master (
    output wrt_smpl, lft_in, rht_in, clr_ovr,
    input  sequencing, lft_out, rht_out, filt_vld, primed, overrun
  );

  modport slave (
    input  wrt_smpl, lft_in, rht_in, clr_ovr,
    output sequencing, lft_out, rht_out, filt_vld, primed, overrun
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - stereo sample history buffer and MAC-pass sequencer for the FIR filter
module fir_seq_ctrl #(
  parameter int TAPS = 1021,
  parameter int AW   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  fir_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {FILL, IDLE, RUN, DONE} state_t;

  localparam logic [AW-1:0] LAST    = AW'(TAPS - 1);
  localparam logic [AW-1:0] CYC_END = AW'(TAPS);

  state_t        state, state_nxt;
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] wptr, rptr, cyc;
  logic [AW-1:0] wptr_inc, rptr_inc;
  logic          hold_vld;
  logic [31:0]   hold_data;
  logic          ovr;
  logic [15:0]   lft_q, rht_q;

  logic          wr_en;
  logic [31:0]   wr_data;
  logic          commit;
  logic          cap;
  logic          ovr_set;
  logic          seq;
  logic          vld;

  assign wptr_inc = (wptr == LAST) ? '0 : wptr + 1'b1;
  assign rptr_inc = (rptr == LAST) ? '0 : rptr + 1'b1;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = {bus.lft_in, bus.rht_in};
    commit    = 1'b0;
    seq       = 1'b0;
    vld       = 1'b0;
    case (state)
      // wptr doubles as the fill count: it only starts wrapping once primed
      FILL: begin
        if (bus.wrt_smpl) begin
          wr_en = 1'b1;
          if (wptr == LAST) state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (hold_vld) begin
          wr_en     = 1'b1;
          wr_data   = hold_data;
          commit    = 1'b1;
          state_nxt = RUN;
        end else if (bus.wrt_smpl) begin
          wr_en     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        seq = 1'b1;
        if (cyc == CYC_END) state_nxt = DONE;
      end
      DONE: begin
        vld = 1'b1;
        if (hold_vld) begin
          wr_en     = 1'b1;
          wr_data   = hold_data;
          commit    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = FILL;
    endcase
    // samples that cannot go straight into the buffer park in the holding register
    cap     = bus.wrt_smpl && (state == RUN || state == DONE || (state == IDLE && hold_vld));
    ovr_set = cap && hold_vld && !commit;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wptr      <= '0;
      rptr      <= '0;
      cyc       <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
      ovr       <= 1'b0;
      lft_q     <= '0;
      rht_q     <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en) wptr <= wptr_inc;
      if (cap) begin
        hold_data <= {bus.lft_in, bus.rht_in};
        hold_vld  <= 1'b1;
      end else if (commit) begin
        hold_vld <= 1'b0;
      end
      if (ovr_set)          ovr <= 1'b1;
      else if (bus.clr_ovr) ovr <= 1'b0;
      // every RUN entry writes a sample, so the post-write pointer is the oldest entry
      if (state_nxt == RUN && state != RUN) begin
        cyc  <= '0;
        rptr <= wptr_inc;
      end else if (state == RUN) begin
        cyc <= cyc + 1'b1;
        if (cyc != CYC_END) begin
          {lft_q, rht_q} <= mem[rptr];
          rptr           <= rptr_inc;
        end
      end
    end
  end

  assign bus.sequencing = seq;
  assign bus.filt_vld   = vld;
  assign bus.primed     = (state != FILL);
  assign bus.overrun    = ovr;
  assign bus.lft_out    = lft_q;
  assign bus.rht_out    = rht_q;

endmodule
